// File: rtl/cfs_sc_fifo.sv
// Single-clock FIFO with any depth, runtime almost-full/almost-empty thresholds,
// synchronous flush, peak-level watermark and optional drop-on-full counting.
module cfs_sc_fifo #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned DROP_ON_FULL   = 0,
  parameter int unsigned DROP_CNT_WIDTH = 8,
  localparam int unsigned PTR_WIDTH     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int unsigned LVL_WIDTH     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      push_valid,
  input  logic [DATA_WIDTH-1:0]     push_data,
  output logic                      push_ready,
  output logic                      pop_valid,
  output logic [DATA_WIDTH-1:0]     pop_data,
  input  logic                      pop_ready,
  output logic [LVL_WIDTH-1:0]      fifo_lvl,
  output logic                      full,
  output logic                      empty,
  input  logic [LVL_WIDTH-1:0]      af_thr,
  input  logic [LVL_WIDTH-1:0]      ae_thr,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [LVL_WIDTH-1:0]      max_lvl,
  input  logic                      clr_max,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  input  logic                      clr_drop
);

  localparam logic [LVL_WIDTH-1:0] LVL_FULL = LVL_WIDTH'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LVL_WIDTH-1:0]      lvl_q, lvl_d;
  logic [LVL_WIDTH-1:0]      max_lvl_q, max_lvl_d;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      push_acc, pop_acc, drop_evt;

  // Explicit wrap compare so non-power-of-2 depths index only valid entries.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  always_comb begin
    full         = (lvl_q == LVL_FULL);
    empty        = (lvl_q == '0);
    push_ready   = (DROP_ON_FULL != 0) ? 1'b1 : (!full && !flush);
    pop_valid    = !empty && !flush;
    pop_acc      = pop_valid && pop_ready;
    // In drop mode a full FIFO still takes a push when the head leaves this cycle.
    push_acc     = push_valid && push_ready && !flush && (!full || pop_acc);
    drop_evt     = (DROP_ON_FULL != 0) && push_valid && full && !flush && !pop_acc;
    pop_data     = mem_q[rd_ptr_q];
    fifo_lvl     = lvl_q;
    max_lvl      = max_lvl_q;
    drop_cnt     = drop_cnt_q;
    almost_full  = (lvl_q >= af_thr);
    almost_empty = (lvl_q <= ae_thr);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    lvl_d    = lvl_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      lvl_d    = '0;
    end else begin
      if (pop_acc)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      case ({push_acc, pop_acc})
        2'b10:   lvl_d = lvl_q + LVL_WIDTH'(1);
        2'b01:   lvl_d = lvl_q - LVL_WIDTH'(1);
        default: lvl_d = lvl_q;
      endcase
    end
  end

  always_comb begin
    max_lvl_d = (clr_max || (lvl_d > max_lvl_q)) ? lvl_d : max_lvl_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_drop) begin
      drop_cnt_d = '0;
    end else if (drop_evt && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      lvl_q      <= '0;
      max_lvl_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      lvl_q      <= lvl_d;
      max_lvl_q  <= max_lvl_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: doc/cfs_sc_fifo.md
Name: cfs_sc_fifo

Overview:
Single-clock FIFO and successor to the team's dual-clock synchronization FIFO, for datapaths where producer and consumer share one clock. Adds features the previous FIFO lacks: any depth, including non-power-of-2; runtime almost-full/almost-empty thresholds; synchronous flush; peak-level watermark; optional drop-on-full mode with a saturating drop counter. Storage is written on accept, and read data is first-word-fall-through from memory.

Parameters:
DATA_WIDTH, 32, data bits; must be >= 1.
FIFO_DEPTH, 8, entries; must be >= 1; power of 2 not required.
DROP_ON_FULL, 0, 0 = backpressure when full; 1 = push_ready always 1 and pushes while full are discarded and counted.
DROP_CNT_WIDTH, 8, width of drop_cnt.
Derived: PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1; LVL_WIDTH = $clog2(FIFO_DEPTH+1).

Ports:
clk  input  1  clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
flush  input  1  synchronous flush
push_valid  input  1  producer has data
push_data  input  DATA_WIDTH  write data
push_ready  output  1  FIFO accepts push this cycle
pop_valid  output  1  pop_data valid
pop_data  output  DATA_WIDTH  head entry
pop_ready  input  1  consumer takes head
fifo_lvl  output  LVL_WIDTH  current occupancy
full  output  1  fifo_lvl == FIFO_DEPTH
empty  output  1  fifo_lvl == 0
af_thr  input  LVL_WIDTH  almost-full threshold
ae_thr  input  LVL_WIDTH  almost-empty threshold
almost_full  output  1  fifo_lvl >= af_thr
almost_empty  output  1  fifo_lvl <= ae_thr
max_lvl  output  LVL_WIDTH  peak occupancy since reset/clear
clr_max  input  1  watermark clear
drop_cnt  output  DROP_CNT_WIDTH  discarded-push count (mode 1)
clr_drop  input  1  drop counter clear

Behaviour:
- Reset (async, reset_n=0): rd_ptr, wr_ptr, fifo_lvl, max_lvl and drop_cnt cleared immediately, independent of clk. Outputs during/after reset: empty=1, full=0, pop_valid=0, push_ready=1, almost_empty=1; almost_full = (af_thr == 0). Memory is not reset. pop_data is don't-care while pop_valid=0. Reset mid-operation discards all contents.
- Accept conditions: push accepted = push_valid & push_ready & !flush. Pop accepted = pop_valid & pop_ready.
- push_ready: mode 0 = !full & !flush, independent of push_valid. Mode 1 = constant 1.
- pop_valid = !empty & !flush.
- pop_data = mem[rd_ptr], combinational. A pushed word is visible on pop_data the cycle after acceptance; there is no same-cycle bypass when empty.
- Pointers: advance by 1 on accept and wrap from FIFO_DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- fifo_lvl is a registered counter: +1 push only, -1 pop only, unchanged on both or neither.
- Full plus pop_ready plus push_valid (mode 0): push_ready=0, so only the pop occurs; level goes to FIFO_DEPTH-1.
- Drop (mode 1): push_valid & full & !flush & !pop-accepted discards the data, and drop_cnt increments, saturating at 2^DROP_CNT_WIDTH-1. A push while full with a same-cycle pop is accepted and not counted. In mode 0, drop_cnt stays 0.
- clr_drop: drop_cnt <= 0 next cycle. clr_drop overrides a same-cycle increment.
- Flush: on a cycle with flush=1, next cycle pointers and level are 0. Push/pop in the flush cycle are ignored and not counted as drops. max_lvl and drop_cnt are unaffected.
- max_lvl: each cycle max_lvl <= max(max_lvl, next_lvl). clr_max loads next_lvl instead.
- Thresholds: almost_full and almost_empty are combinational from the registered fifo_lvl and the current af_thr/ae_thr. Threshold values above FIFO_DEPTH are legal: almost_full is then never asserted, and almost_empty is always asserted.
- FIFO_DEPTH=1: behaves as a single-entry buffer; full and empty are mutually exclusive.

Test Plan:
1. Reset, DEPTH=4, DW=8, af_thr=3, ae_thr=1. Assert reset_n=0 mid-traffic at level 2 -> immediately lvl=0, empty=1, pop_valid=0, push_ready=1, max_lvl=0, drop_cnt=0, almost_empty=1, almost_full=0.
2. Fill/drain. Push 0x11,0x22,0x33,0x44 back-to-back, pop_ready=0 -> lvl 1,2,3,4; almost_full from lvl 3; full=1 and push_ready=0 after the 4th. Then pop_ready=1 -> 0x11,0x22,0x33,0x44 in order, empty after 4 pops, max_lvl=4.
3. Simultaneous push/pop. At lvl 2, push+pop for 5 cycles -> lvl stays 2 and order is preserved. At full with push_valid=1, pop_ready=1 -> one pop only, lvl=3.
4. Wrap, non-power-of-2. DEPTH=3, stream 10 words 0x00..0x09 with random pop_ready -> output 0x00..0x09 in order, lvl never exceeds 3.
5. Drop mode. DROP_ON_FULL=1, DEPTH=4, DROP_CNT_WIDTH=2. Push 9 words, no pops -> first 4 stored; drop_cnt=3 (saturated after 3 of the 5 drops); push_ready constantly 1. Then clr_drop -> drop_cnt=0.
6. Flush/watermark. At lvl 3, flush=1 with push_valid=1 -> next cycle lvl=0, empty=1, push not stored, max_lvl=3. Push 1 word, then clr_max -> max_lvl=1.
